cordic_sincos_rotator: RTL and testbench
========================================

// Module: cordic_sincos_rotator
// PURPOSE
//  Iterative CORDIC in rotation mode. Converts a 14-bit signed angle into cos/sin.
//  It is the inverse partner of the vectoring path, which turns (X,Y) into an angle and
//  then maps the result back to quadrants 2/3 when X<0.
//  This block works the other way round:
//   - before iterating, it pre-maps angles in quadrants 2/3 into [-pi/2, pi/2];
//   - after iterating, it negates X/Y to restore the original quadrant.
//  Sits between the angle source and the sin/cos consumers; uses a start/busy/done handshake.
// PARAMETERS
//  WIDTH  14  I/O width. Two's complement Q2.11: 1 sign, 2 integer, 11 fraction bits.
//             The atan table and constants are fixed for 14.
//  ITER   12  Micro-rotations, legal 1..12. Latency = ITER+2 cycles.
//  GUARD  2   Extra LSB guard bits on the internal x/y/z datapath.
// PORTS
//  clk        in   1      Rising-edge clock.
//  rst_n      in   1      Asynchronous reset, active-low.
//  start      in   1      Request. Sampled only in IDLE.
//  angle_in   in   WIDTH  Signed angle in radians, Q2.11. Legal range [-6434, 6434] (+/-pi).
//  busy       out  1      High from the accepting edge until done.
//  done       out  1      One-cycle pulse: cos_out/sin_out/range_err are valid.
//  cos_out    out  WIDTH  Signed cos, Q2.11 (1.0 = 2048). Held until the next done.
//  sin_out    out  WIDTH  Signed sin, Q2.11. Held until the next done.
//  range_err  out  1      Valid with done. 1 = angle_in was outside +/-6434.
// BEHAVIOUR
//  Reset: rst_n=0 forces state IDLE and zeroes everything, immediately, including mid-operation.
//   - Outputs: busy=0, done=0, cos_out=0, sin_out=0, range_err=0.
//   - Internal: x=y=z=0, iteration count i=0, negate=0.
//  FSM: IDLE -> MAP -> ROT (ITER cycles) -> POST -> IDLE.
//  IDLE: start=1 at an edge captures angle_in and sets busy=1. start=0 stays in IDLE.
//  MAP (1 cycle), quadrant pre-map with PI=6434, PI_2=3217:
//   - a > 6434 or a < -6434: range_err latched to 1; z=0, negate=0.
//   - a > 3217:              z = a - 6434; negate=1.
//   - a < -3217:             z = a + 6434; negate=1.
//   - otherwise:             z = a;        negate=0.
//   - Always: x = 1244 (1/K pre-scale), y = 0; all shifted left by GUARD.
//  ROT, one micro-rotation per cycle for i = 0..ITER-1:
//   - d = +1 if z >= 0, else -1.
//   - x' = x - d*(y >>> i);  y' = y + d*(x >>> i);  z' = z - d*ATAN[i].
//   - Shifts are arithmetic. Adds are WIDTH+GUARD bits wide. No saturation is required:
//     |x|,|y| <= 1.65 in Q2.11 fits.
//   - ATAN[0..11] = 1608,950,502,255,128,64,32,16,8,4,2,1, each shifted left by GUARD.
//  POST (1 cycle):
//   - r = x,y >>> GUARD (arithmetic truncate); negated when negate=1.
//   - range_err=1 forces cos_out=sin_out=0.
//   - Registers cos_out/sin_out/range_err; done=1 and busy=0 on the same edge.
//  Timing: start sampled at edge E0 -> done high in the cycle after edge E0+ITER+2
//   (14 cycles at default). range_err is cleared at each new accept.
//  start while busy: ignored and not queued.
//   - start may be asserted in the done cycle: the state is IDLE then, so it is accepted.
//   - Back-to-back throughput is 1 result per ITER+3 cycles.
//  angle_in is read only at the accepting edge; later changes have no effect.
//  Boundaries: +/-3217 take the non-negate path. +/-6434 take the negate path with z=0.
// TESTING (tolerance +/-6 LSB on cos/sin unless noted)
//  1. angle_in=0, start 1 cycle -> done after 14 cycles; cos~2048, sin~0, range_err=0.
//  2. angle_in=3217 -> cos~0, sin~2048, negate=0. angle_in=-1608 -> cos~1448, sin~-1448.
//  3. angle_in=6434 -> cos~-2048, sin~0. angle_in=-4825 -> cos~-1448, sin~-1448 (negate path).
//  4. angle_in=7000 -> done at cycle 14, range_err=1, cos=sin=0. Next legal op clears range_err.
//  5. start held high 40 cycles -> done pulses exactly every 15 cycles; busy never drops
//     except in done cycles.
//  6. rst_n=0 during ROT i=5 -> busy/done/outputs 0 asynchronously. Release, angle_in=0 -> case-1 result.

Source files
------------

// File: rtl/cordic_sincos_rotator.sv
// Iterative rotation-mode CORDIC: signed Q2.11 angle in, cos/sin out.
// Angles beyond +/-pi/2 are folded by pi and the result negated afterwards.
module cordic_sincos_rotator #(
    parameter int WIDTH = 14,
    parameter int ITER  = 12,
    parameter int GUARD = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] angle_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] cos_out,
    output logic [WIDTH-1:0] sin_out,
    output logic             range_err
);
    localparam int DW = WIDTH + GUARD;
    localparam int IW = 4;
    localparam logic signed [WIDTH-1:0] PI   = WIDTH'(6434);
    localparam logic signed [WIDTH-1:0] PI_2 = WIDTH'(3217);

    typedef enum logic [1:0] {IDLE, MAP, ROT, POST} state_t;
    state_t state, state_nxt;

    logic signed [WIDTH-1:0] a;
    logic signed [DW-1:0]    x, y, z;
    logic [IW-1:0]           i;
    logic                    neg, err;

    function automatic logic signed [DW-1:0] atan_lut(input logic [IW-1:0] k);
        logic signed [DW-1:0] v;
        case (k)
            4'd0:    v = DW'(1608);
            4'd1:    v = DW'(950);
            4'd2:    v = DW'(502);
            4'd3:    v = DW'(255);
            4'd4:    v = DW'(128);
            4'd5:    v = DW'(64);
            4'd6:    v = DW'(32);
            4'd7:    v = DW'(16);
            4'd8:    v = DW'(8);
            4'd9:    v = DW'(4);
            4'd10:   v = DW'(2);
            4'd11:   v = DW'(1);
            default: v = '0;
        endcase
        return v <<< GUARD;
    endfunction

    logic signed [DW-1:0]    xs, ys, at;
    logic                    d_pos;
    logic signed [WIDTH-1:0] a_lo, a_hi;

    always_comb begin
        xs    = x >>> i;
        ys    = y >>> i;
        at    = atan_lut(i);
        d_pos = ~z[DW-1];
        // Fold by pi; only meaningful on the branch that selects it.
        a_lo  = a - PI;
        a_hi  = a + PI;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MAP;
            MAP:     state_nxt = ROT;
            ROT:     if (i == IW'(ITER - 1)) state_nxt = POST;
            POST:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a         <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            i         <= '0;
            neg       <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cos_out   <= '0;
            sin_out   <= '0;
            range_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a         <= angle_in;
                    busy      <= 1'b1;
                    err       <= 1'b0;
                    range_err <= 1'b0;
                end
                MAP: begin
                    x <= DW'(1244) <<< GUARD;
                    y <= '0;
                    i <= '0;
                    if (a > PI || a < -PI) begin
                        err <= 1'b1;
                        z   <= '0;
                        neg <= 1'b0;
                    end else if (a > PI_2) begin
                        z   <= {a_lo, {GUARD{1'b0}}};
                        neg <= 1'b1;
                    end else if (a < -PI_2) begin
                        z   <= {a_hi, {GUARD{1'b0}}};
                        neg <= 1'b1;
                    end else begin
                        z   <= {a, {GUARD{1'b0}}};
                        neg <= 1'b0;
                    end
                end
                ROT: begin
                    x <= d_pos ? x - ys : x + ys;
                    y <= d_pos ? y + xs : y - xs;
                    z <= d_pos ? z - at : z + at;
                    i <= i + 1'b1;
                end
                POST: begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    range_err <= err;
                    if (err) begin
                        cos_out <= '0;
                        sin_out <= '0;
                    end else if (neg) begin
                        cos_out <= WIDTH'(-(x >>> GUARD));
                        sin_out <= WIDTH'(-(y >>> GUARD));
                    end else begin
                        cos_out <= WIDTH'(x >>> GUARD);
                        sin_out <= WIDTH'(y >>> GUARD);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_sincos_rotator.sv
// Directed-vector bench for cordic_sincos_rotator: latency, quadrant folding,
// range errors, back-to-back throughput and asynchronous reset.
module tb_cordic_sincos_rotator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] angle_in = '0;
    logic        busy, done, range_err;
    logic [13:0] cos_out, sin_out;

    cordic_sincos_rotator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .angle_in(angle_in),
        .busy(busy), .done(done), .cos_out(cos_out), .sin_out(sin_out),
        .range_err(range_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic signed [13:0] r_cos, r_sin;
    logic r_err, r_busy0, r_to;
    int   r_lat;

    // Issue one request and wait (bounded) for done. angle_in is scrambled
    // right after the accepting edge to show it is not re-read.
    task automatic run_op(input logic signed [13:0] a);
        bit got;
        @(negedge clk);
        angle_in = a;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        angle_in = ~a;
        r_busy0  = busy;
        got      = 1'b0;
        r_lat    = 0;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got   = 1'b1;
                r_lat = n;
            end
        end
        r_to  = !got;
        r_cos = cos_out;
        r_sin = sin_out;
        r_err = range_err;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, range_err, cos_out, sin_out} !== 31'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b cos=%0d sin=%0d, want all 0",
                     busy, done, range_err, cos_out, sin_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        run_op(14'sd0);
        checks++;
        if (r_busy0 !== 1'b1) begin errors++; $display("FAIL zero_busy_after_accept: got %b want 1", r_busy0); end
        checks++;
        if (r_to || r_lat != 14) begin errors++; $display("FAIL zero_latency: got %0d (timeout=%b) want 14", r_lat, r_to); end
        checks++;
        if (int'(r_cos) > 2054 || int'(r_cos) < 2042) begin errors++; $display("FAIL zero_cos: got %0d want 2048+/-6", r_cos); end
        checks++;
        if (int'(r_sin) > 6 || int'(r_sin) < -6) begin errors++; $display("FAIL zero_sin: got %0d want 0+/-6", r_sin); end
        checks++;
        if (r_err !== 1'b0) begin errors++; $display("FAIL zero_range_err: got %b want 0", r_err); end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done_pulse: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_quadrants();
        int ang [8] = '{3217, -1608, 6434, -4825, -3217, -6434, 1608, 4825};
        int ec  [8] = '{0, 1448, -2048, -1448, 0, -2048, 1448, -1448};
        int es  [8] = '{2048, -1448, 0, -1448, -2048, 0, 1448, 1448};
        for (int k = 0; k < 8; k++) begin
            run_op(14'(ang[k]));
            checks++;
            if (r_to || r_lat != 14 || r_err !== 1'b0) begin
                errors++;
                $display("FAIL quad_timing a=%0d: got lat=%0d err=%b want 14 0", ang[k], r_lat, r_err);
            end
            checks++;
            if (int'(r_cos) > ec[k] + 6 || int'(r_cos) < ec[k] - 6) begin
                errors++;
                $display("FAIL quad_cos a=%0d: got %0d want %0d+/-6", ang[k], r_cos, ec[k]);
            end
            checks++;
            if (int'(r_sin) > es[k] + 6 || int'(r_sin) < es[k] - 6) begin
                errors++;
                $display("FAIL quad_sin a=%0d: got %0d want %0d+/-6", ang[k], r_sin, es[k]);
            end
        end
    endtask

    task automatic test_range();
        int ang [3] = '{7000, -7000, 6435};
        for (int k = 0; k < 3; k++) begin
            run_op(14'(ang[k]));
            checks++;
            if (r_to || r_lat != 14) begin errors++; $display("FAIL range_latency a=%0d: got %0d want 14", ang[k], r_lat); end
            checks++;
            if (r_err !== 1'b1 || r_cos !== 14'sd0 || r_sin !== 14'sd0) begin
                errors++;
                $display("FAIL range_result a=%0d: got err=%b cos=%0d sin=%0d want 1 0 0", ang[k], r_err, r_cos, r_sin);
            end
        end
        run_op(14'sd0);
        checks++;
        if (r_err !== 1'b0 || int'(r_cos) < 2042) begin
            errors++;
            $display("FAIL range_clear: got err=%b cos=%0d want 0 ~2048", r_err, r_cos);
        end
    endtask

    task automatic test_back_to_back();
        int last = -1;
        int pulses = 0;
        bit got;
        @(negedge clk);
        angle_in = 14'sd0;
        start    = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if (busy !== ~done) begin
                errors++;
                $display("FAIL b2b_busy cycle=%0d: got busy=%b done=%b want busy=!done", n, busy, done);
            end
            if (done) begin
                pulses++;
                if (last >= 0) begin
                    checks++;
                    if (n - last != 15) begin errors++; $display("FAIL b2b_period: got %0d want 15", n - last); end
                end
                last = n;
            end
        end
        start = 1'b0;
        checks++;
        if (pulses != 4) begin errors++; $display("FAIL b2b_pulses: got %0d want 4", pulses); end
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(posedge clk);
            #1;
            if (!busy) got = 1'b1;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL b2b_drain: busy stuck, want 0 within 20 cycles"); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        angle_in = 14'sd1608;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, range_err, cos_out, sin_out} !== 31'd0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b err=%b cos=%0d sin=%0d want all 0",
                     busy, done, range_err, cos_out, sin_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(14'sd0);
        checks++;
        if (r_to || r_lat != 14 || r_err !== 1'b0 || int'(r_cos) > 2054 || int'(r_cos) < 2042
            || int'(r_sin) > 6 || int'(r_sin) < -6) begin
            errors++;
            $display("FAIL reset_mid_recover: got lat=%0d err=%b cos=%0d sin=%0d want 14 0 2048 0",
                     r_lat, r_err, r_cos, r_sin);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_quadrants();
        test_range();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
